ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
// - ID->EX pipeline register with operand forwarding muxes; consumes the forwarding unit's fwd1/fwd2 selects.
// - Selects each source operand from the MEM result, WB result or register-file read data.
// - Latches operands plus rd into the EX stage under a valid/ready handshake with stall and flush.
// - Stalls ID for one cycle on a load-use hazard, i.e. when a MEM-stage load must forward its result.
// PARAMETERS
// - DATA_W   16  operand / result width
// - REG_AW   3   register address width (8 architectural registers)
// - CNT_W    16  forwarding statistics counter width (only with FWD_STATS_EN)
// PORTS
// - clk          in   1        rising-edge clock
// - rst_n        in   1        asynchronous active-low reset
// - id_valid     in   1        ID stage presents an instruction
// - id_ready     out  1        stage accepts the ID instruction this cycle
// - id_rd        in   REG_AW   destination register of the ID instruction
// - rs1_data     in   DATA_W   register-file read port 1
// - rs2_data     in   DATA_W   register-file read port 2
// - fwd1         in   2        operand A select: 0=MEM, 1=WB, 2=regfile, 3=regfile
// - fwd2         in   2        operand B select, same encoding
// - mem_result   in   DATA_W   value in the MEM stage
// - mem_is_load  in   1        MEM-stage instruction is a load (mem_result not yet valid)
// - wb_result    in   DATA_W   value being written back
// - flush        in   1        squash the EX slot and the ID capture (branch taken)
// - ex_ready     in   1        EX stage can consume ex_* this cycle
// - ex_valid     out  1        ex_a/ex_b/ex_rd hold a live instruction
// - ex_a         out  DATA_W   latched operand A
// - ex_b         out  DATA_W   latched operand B
// - ex_rd        out  REG_AW   latched destination register
// - fwd_count    out  2*CNT_W  {B count, A count} of MEM/WB forwards (FWD_STATS_EN only)
// BEHAVIOUR
// - Reset (rst_n low, async): ex_valid=0, ex_a=0, ex_b=0, ex_rd=0, fwd_count=0; id_ready follows its comb equation.
// - Mux (comb): opA = fwd1==0 ? mem_result : fwd1==1 ? wb_result : rs1_data; same for opB with fwd2.
// - load_use (comb) = id_valid & mem_is_load & (fwd1==0 | fwd2==0).
// - id_ready (comb) = (!ex_valid | ex_ready) & !load_use & !flush.
// - Capture on posedge when id_valid & id_ready: ex_a<=opA, ex_b<=opB, ex_rd<=id_rd, ex_valid<=1. Latency 1 cycle.
// - Drain: ex_valid & ex_ready & no capture -> ex_valid<=0; data regs hold their last value.
// - Hold: ex_valid & !ex_ready -> all ex_* frozen. Operands are NOT re-forwarded while held; values are fixed at capture.
// - Load-use: no capture; if ex_valid & ex_ready the slot drains to a bubble (ex_valid=0). Next cycle the load is in WB,
//   fwd selects 1 and capture proceeds. Exactly one bubble per load-use pair.
// - Flush: ex_valid<=0 on the next edge regardless of capture/ex_ready; ex data regs hold. Flush dominates all other events.
// - Simultaneous drain and capture (ex_valid & ex_ready & id_valid & id_ready): new instruction replaces old, ex_valid stays 1.
// - Reset mid-transfer: the in-flight instruction is lost; ID must re-present it after reset.
// - fwd==3 is treated as the regfile select; no error is flagged.
// CONFIGURATION
// - FWD_STATS_EN defined: on each capture, the A counter +1 if fwd1 is 0 or 1; the B counter +1 if fwd2 is 0 or 1.
//   Counters saturate at all-ones, are not cleared by flush, and are cleared only by reset.
// - FWD_STATS_EN undefined: counters are not built; fwd_count is tied to 0.
// TESTING
// - Reset: rst_n=0 mid-cycle -> ex_valid=0, ex_a=ex_b=0 immediately (async), id_ready=1 when id_valid=0.
// - Forwarding: fwd1=0, fwd2=1, mem_result=0x1111, wb_result=0x2222, rs=0x3333, id_rd=5 -> next cycle ex_a=0x1111, ex_b=0x2222, ex_rd=5.
// - Load-use: fwd1=0, mem_is_load=1 -> id_ready=0, ex_valid=0 next cycle; then fwd1=1, wb_result=0xBEEF -> ex_a=0xBEEF.
// - Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_a/ex_b/ex_rd stable, id_ready=0; ex_ready=1 -> accept the next instruction.
// - Flush: flush=1 with id_valid=1 and ex_valid=1 -> id_ready=0, ex_valid=0 next cycle.
// - FWD_STATS_EN: 3 captures with fwd1=0 and fwd2=2 -> fwd_count A=3, B=0; saturation from preload at 0xFFFF stays 0xFFFF.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// ID->EX handshake bundle for ex_operand_stage.
// master: ID/EX neighbours (drive ID instruction, consume ex_*).
// slave : ex_operand_stage (accepts ID instruction, presents ex_*).
// Signals: id_valid/id_ready/id_rd, rs1_data/rs2_data, fwd1/fwd2,
//          ex_valid/ex_ready/ex_a/ex_b/ex_rd.
interface ex_operand_stage_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
);
   logic              id_valid;
   logic              id_ready;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [1:0]        fwd1;
   logic [1:0]        fwd2;
   logic              ex_ready;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [REG_AW-1:0] ex_rd;

   modport master (
      output id_valid, id_rd, rs1_data, rs2_data, fwd1, fwd2, ex_ready,
      input  id_ready, ex_valid, ex_a, ex_b, ex_rd
   );

   modport slave (
      input  id_valid, id_rd, rs1_data, rs2_data, fwd1, fwd2, ex_ready,
      output id_ready, ex_valid, ex_a, ex_b, ex_rd
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register with operand forwarding muxes and load-use stall.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (slave)   ID handshake, regfile data, fwd selects, EX handshake/outputs
//   mem_result    MEM-stage value (forward select 0)
//   mem_is_load   MEM-stage instruction is a load; its result cannot be forwarded yet
//   wb_result     WB-stage value (forward select 1)
//   flush         squash the EX slot and block the ID capture
//   fwd_count     {B count, A count} of MEM/WB forwards
// Optional feature macro: FWD_STATS_EN builds the saturating forward counters;
// without it fwd_count is tied to zero.
module ex_operand_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ex_operand_stage_if.slave    bus,
   input  logic [DATA_W-1:0]    mem_result,
   input  logic                 mem_is_load,
   input  logic [DATA_W-1:0]    wb_result,
   input  logic                 flush,
   output logic [2*CNT_W-1:0]   fwd_count
);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              load_use;
   logic              capture;
   logic              ex_valid_q;
   logic [DATA_W-1:0] ex_a_q;
   logic [DATA_W-1:0] ex_b_q;
   logic [REG_AW-1:0] ex_rd_q;

   // Operand forwarding muxes; select 3 falls back to the register file
   always_comb begin
      op_a = bus.rs1_data;
      op_b = bus.rs2_data;
      case (bus.fwd1)
         2'd0:    op_a = mem_result;
         2'd1:    op_a = wb_result;
         default: op_a = bus.rs1_data;
      endcase
      case (bus.fwd2)
         2'd0:    op_b = mem_result;
         2'd1:    op_b = wb_result;
         default: op_b = bus.rs2_data;
      endcase
   end

   // A MEM-stage load cannot supply its data yet: hold ID for one cycle
   assign load_use     = bus.id_valid & mem_is_load & ((bus.fwd1 == 2'd0) | (bus.fwd2 == 2'd0));
   assign bus.id_ready = (~ex_valid_q | bus.ex_ready) & ~load_use & ~flush;
   assign capture      = bus.id_valid & bus.id_ready;

   // EX slot: flush kills, capture loads, otherwise drain when consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_rd_q    <= '0;
      end else if (flush) begin
         ex_valid_q <= 1'b0;
      end else if (capture) begin
         ex_valid_q <= 1'b1;
         ex_a_q     <= op_a;
         ex_b_q     <= op_b;
         ex_rd_q    <= bus.id_rd;
      end else if (bus.ex_ready) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign bus.ex_valid = ex_valid_q;
   assign bus.ex_a     = ex_a_q;
   assign bus.ex_b     = ex_b_q;
   assign bus.ex_rd    = ex_rd_q;

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   // Saturating per-operand forward counters; only reset clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (capture) begin
         if (!bus.fwd1[1] && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + CNT_W'(1);
         if (!bus.fwd2[1] && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + CNT_W'(1);
      end
   end

   assign fwd_count = {cnt_b, cnt_a};
`else
   assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
// Inputs change on the falling edge; registered outputs are checked on the
// following falling edge, combinational id_ready 1 ns after driving.
module tb_ex_operand_stage;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned CNT_W  = 16;

   logic                clk;
   logic                rst_n;
   logic [DATA_W-1:0]   mem_result;
   logic                mem_is_load;
   logic [DATA_W-1:0]   wb_result;
   logic                flush;
   logic [2*CNT_W-1:0]  fwd_count;

   int total;
   int bad;

   ex_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus_i ();

   ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_i),
      .mem_result  (mem_result),
      .mem_is_load (mem_is_load),
      .wb_result   (wb_result),
      .flush       (flush),
      .fwd_count   (fwd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      bus_i.id_valid = 1'b0;
      bus_i.id_rd    = '0;
      bus_i.rs1_data = '0;
      bus_i.rs2_data = '0;
      bus_i.fwd1     = 2'd2;
      bus_i.fwd2     = 2'd2;
      bus_i.ex_ready = 1'b1;
      mem_result     = '0;
      mem_is_load    = 1'b0;
      wb_result      = '0;
      flush          = 1'b0;
   endtask

   task automatic drive_id(input logic [1:0] f1, input logic [1:0] f2,
                           input logic [15:0] r1, input logic [15:0] r2,
                           input logic [2:0] rd);
      bus_i.id_valid = 1'b1;
      bus_i.fwd1     = f1;
      bus_i.fwd2     = f2;
      bus_i.rs1_data = r1;
      bus_i.rs2_data = r2;
      bus_i.id_rd    = rd;
   endtask

   task automatic chk_ex(input string name, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] rd);
      total++;
      if (bus_i.ex_valid !== v || bus_i.ex_a !== a || bus_i.ex_b !== b || bus_i.ex_rd !== rd) begin
         bad++;
         $display("FAIL %s: got v=%b a=%h b=%h rd=%0d, expected v=%b a=%h b=%h rd=%0d",
                  name, bus_i.ex_valid, bus_i.ex_a, bus_i.ex_b, bus_i.ex_rd, v, a, b, rd);
      end
   endtask

   task automatic chk_rdy(input string name, input logic exp);
      #1;
      total++;
      if (bus_i.id_ready !== exp) begin
         bad++;
         $display("FAIL %s: id_ready got %b expected %b", name, bus_i.id_ready, exp);
      end
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_ex("reset_initial", 1'b0, 16'h0, 16'h0, 3'd0);
      drive_id(2'd2, 2'd3, 16'h1234, 16'h5678, 3'd4);
      @(negedge clk);
      chk_ex("pre_reset_load", 1'b1, 16'h1234, 16'h5678, 3'd4);
      idle();
      bus_i.ex_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk_ex("async_reset", 1'b0, 16'h0, 16'h0, 3'd0);
      chk_rdy("reset_id_ready", 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      bus_i.ex_ready = 1'b1;
   endtask

   task automatic test_forwarding();
      idle();
      mem_result = 16'h1111;
      wb_result  = 16'h2222;
      drive_id(2'd0, 2'd1, 16'h3333, 16'h3333, 3'd5);
      chk_rdy("fwd_ready", 1'b1);
      @(negedge clk);
      chk_ex("fwd_mem_wb", 1'b1, 16'h1111, 16'h2222, 3'd5);
      drive_id(2'd2, 2'd3, 16'h3333, 16'h4444, 3'd6);
      @(negedge clk);
      chk_ex("fwd_regfile_sel2_3", 1'b1, 16'h3333, 16'h4444, 3'd6);
      drive_id(2'd1, 2'd0, 16'h3333, 16'h4444, 3'd3);
      @(negedge clk);
      chk_ex("fwd_wb_mem", 1'b1, 16'h2222, 16'h1111, 3'd3);
      idle();
      @(negedge clk);
      chk_ex("drain_holds_data", 1'b0, 16'h2222, 16'h1111, 3'd3);
   endtask

   task automatic test_load_use();
      idle();
      drive_id(2'd2, 2'd2, 16'hAAAA, 16'h0000, 3'd1);
      @(negedge clk);
      chk_ex("lu_prior", 1'b1, 16'hAAAA, 16'h0000, 3'd1);
      drive_id(2'd0, 2'd2, 16'h0000, 16'h0101, 3'd2);
      mem_is_load = 1'b1;
      mem_result  = 16'hDEAD;
      chk_rdy("lu_stall", 1'b0);
      bus_i.fwd1 = 2'd2;
      bus_i.fwd2 = 2'd0;
      chk_rdy("lu_stall_b", 1'b0);
      bus_i.fwd1 = 2'd0;
      bus_i.fwd2 = 2'd2;
      @(negedge clk);
      chk_ex("lu_bubble", 1'b0, 16'hAAAA, 16'h0000, 3'd1);
      mem_is_load = 1'b0;
      bus_i.fwd1  = 2'd1;
      wb_result   = 16'hBEEF;
      chk_rdy("lu_resume", 1'b1);
      @(negedge clk);
      chk_ex("lu_wb_fwd", 1'b1, 16'hBEEF, 16'h0101, 3'd2);
   endtask

   task automatic test_backpressure();
      // ex_valid=1 holding BEEF/0101/2 from the previous test
      idle();
      bus_i.ex_ready = 1'b0;
      drive_id(2'd0, 2'd2, 16'h0000, 16'h6666, 3'd7);
      for (int i = 0; i < 3; i++) begin
         mem_result = 16'h5550 + 16'(i);
         chk_rdy("bp_ready_low", 1'b0);
         @(negedge clk);
         chk_ex("bp_hold", 1'b1, 16'hBEEF, 16'h0101, 3'd2);
      end
      mem_result     = 16'h5555;
      bus_i.ex_ready = 1'b1;
      chk_rdy("bp_release", 1'b1);
      @(negedge clk);
      chk_ex("bp_accept", 1'b1, 16'h5555, 16'h6666, 3'd7);
   endtask

   task automatic test_flush();
      idle();
      bus_i.ex_ready = 1'b0;
      flush = 1'b1;
      drive_id(2'd2, 2'd2, 16'h9999, 16'h8888, 3'd0);
      chk_rdy("flush_ready", 1'b0);
      @(negedge clk);
      chk_ex("flush_kill", 1'b0, 16'h5555, 16'h6666, 3'd7);
      @(negedge clk);
      chk_ex("flush_empty_slot", 1'b0, 16'h5555, 16'h6666, 3'd7);
      flush = 1'b0;
      bus_i.ex_ready = 1'b1;
      chk_rdy("flush_release", 1'b1);
      @(negedge clk);
      chk_ex("post_flush_capture", 1'b1, 16'h9999, 16'h8888, 3'd0);
   endtask

   task automatic test_back_to_back();
      idle();
      for (int i = 0; i < 4; i++) begin
         drive_id(2'd2, 2'd2, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 3'(i));
         @(negedge clk);
         chk_ex("b2b", 1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 3'(i));
      end
      idle();
      @(negedge clk);
      chk_ex("b2b_drain", 1'b0, 16'h0103, 16'h0203, 3'd3);
   endtask

   task automatic test_stats();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_result = 16'h0042;
      for (int i = 0; i < 3; i++) begin
         drive_id(2'd0, 2'd2, 16'h0, 16'h0, 3'd1);
         @(negedge clk);
      end
      idle();
      total++;
`ifdef FWD_STATS_EN
      if (fwd_count !== {16'd0, 16'd3}) begin
         bad++;
         $display("FAIL stats_count: got %h expected %h", fwd_count, {16'd0, 16'd3});
      end
      // Push A past all-ones; it must saturate, B untouched
      drive_id(2'd1, 2'd3, 16'h0, 16'h0, 3'd1);
      repeat (65535) @(negedge clk);
      idle();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (fwd_count !== {16'd0, 16'hFFFF}) begin
         bad++;
         $display("FAIL stats_saturate: got %h expected %h", fwd_count, {16'd0, 16'hFFFF});
      end
`else
      if (fwd_count !== 32'd0) begin
         bad++;
         $display("FAIL stats_tied: got %h expected 0", fwd_count);
      end
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_load_use();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_stats();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
